// File: rtl/com_bus_arbiter_pkg.sv
// Shared cache-cluster package: arbiter state encoding, requester counts and address width.
// Also provides the round-robin pointer advance used when COM_BUS_ARB_RR_EN is defined.
`ifndef ADDRESSSIZE
`define ADDRESSSIZE 32
`endif

package com_bus_arbiter_pkg;

    localparam int N_PROC_DEF  = 8;
    localparam int N_SNOOP_DEF = 4;
    localparam int ADDR_SIZE   = `ADDRESSSIZE;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        OWN     = 3'd1,
        OWN_SNP = 3'd2,
        DRAIN   = 3'd3,
        TURN    = 3'd4
    } arb_state_e;

    // Pointer moves just past the last winner, wrapping at the requester count.
    function automatic logic [2:0] next_ptr(input logic [2:0] idx, input int n);
        return (int'(idx) == n - 1) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/com_bus_arbiter_if.sv
// Request/grant bundle between the cluster caches (master) and the common-bus arbiter (slave).
interface com_bus_arbiter_if #(
    parameter int N_PROC  = 8,
    parameter int N_SNOOP = 4
);
    logic [N_PROC-1:0]  Com_Bus_Req_proc;
    logic [N_PROC-1:0]  Com_Bus_Gnt_proc;
    logic [N_SNOOP-1:0] Com_Bus_Req_snoop;
    logic [N_SNOOP-1:0] Com_Bus_Gnt_snoop;
    logic               Bus_busy;
    logic [2:0]         Gnt_owner;

    modport master (
        output Com_Bus_Req_proc,
        output Com_Bus_Req_snoop,
        input  Com_Bus_Gnt_proc,
        input  Com_Bus_Gnt_snoop,
        input  Bus_busy,
        input  Gnt_owner
    );

    modport slave (
        input  Com_Bus_Req_proc,
        input  Com_Bus_Req_snoop,
        output Com_Bus_Gnt_proc,
        output Com_Bus_Gnt_snoop,
        output Bus_busy,
        output Gnt_owner
    );
endinterface

// File: rtl/com_bus_rr_pick.sv
// Combinational masked priority picker: first requester at or above ptr wins, else lowest index.
// Tying ptr to 0 gives plain fixed priority.
module com_bus_rr_pick #(
    parameter int N  = 8,
    parameter int IW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);
    logic [N-1:0] mask;
    logic [N-1:0] masked;
    logic [N-1:0] sel;
    logic         found;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_mask
            assign mask[gi] = (ptr <= IW'(gi));
        end
    endgenerate

    assign masked = req & mask;
    assign sel    = (|masked) ? masked : req;
    assign any    = |req;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (sel[i] && !found) begin
                gnt[i] = 1'b1;
                idx    = IW'(i);
                found  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/com_bus_arbiter.sv
// Common-bus arbiter: processor ownership, nested snoop grant and one turnaround cycle between owners.
// Define COM_BUS_ARB_RR_EN for round-robin processor priority; default build is fixed priority.
module com_bus_arbiter
    import com_bus_arbiter_pkg::*;
#(
    parameter int N_PROC  = N_PROC_DEF,
    parameter int N_SNOOP = N_SNOOP_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    com_bus_arbiter_if.slave   bus
);
    localparam int SW = (N_SNOOP > 1) ? $clog2(N_SNOOP) : 1;

    localparam logic [2:0] ST_IDLE    = IDLE;
    localparam logic [2:0] ST_OWN     = OWN;
    localparam logic [2:0] ST_OWN_SNP = OWN_SNP;
    localparam logic [2:0] ST_DRAIN   = DRAIN;
    localparam logic [2:0] ST_TURN    = TURN;

    logic [2:0]         state_reg, state_next;
    logic [N_PROC-1:0]  gnt_proc_reg, gnt_proc_next;
    logic [N_SNOOP-1:0] gnt_snoop_reg, gnt_snoop_next;
    logic [2:0]         owner_reg, owner_next;
    logic [SW-1:0]      snp_idx_reg, snp_idx_next;

    logic [2:0]         pick_ptr;
    logic [N_PROC-1:0]  proc_gnt;
    logic [2:0]         proc_idx;
    logic               proc_any;
    logic [N_SNOOP-1:0] snp_gnt;
    logic [SW-1:0]      snp_idx;
    logic               snp_any;
    logic               owner_req;
    logic               snooper_req;

    com_bus_rr_pick #(.N(N_PROC), .IW(3)) u_proc_pick (
        .req (bus.Com_Bus_Req_proc),
        .ptr (pick_ptr),
        .gnt (proc_gnt),
        .idx (proc_idx),
        .any (proc_any)
    );

    com_bus_rr_pick #(.N(N_SNOOP), .IW(SW)) u_snoop_pick (
        .req (bus.Com_Bus_Req_snoop),
        .ptr ('0),
        .gnt (snp_gnt),
        .idx (snp_idx),
        .any (snp_any)
    );

`ifdef COM_BUS_ARB_RR_EN
    logic [2:0] ptr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else if (state_reg == ST_IDLE && proc_any) begin
            ptr_reg <= next_ptr(proc_idx, N_PROC);
        end
    end

    assign pick_ptr = ptr_reg;
`else
    assign pick_ptr = '0;
`endif

    assign owner_req   = bus.Com_Bus_Req_proc[owner_reg];
    assign snooper_req = bus.Com_Bus_Req_snoop[snp_idx_reg];

    always_comb begin
        state_next     = state_reg;
        gnt_proc_next  = gnt_proc_reg;
        gnt_snoop_next = gnt_snoop_reg;
        owner_next     = owner_reg;
        snp_idx_next   = snp_idx_reg;
        case (state_reg)
            ST_IDLE: begin
                if (proc_any) begin
                    state_next    = ST_OWN;
                    gnt_proc_next = proc_gnt;
                    owner_next    = proc_idx;
                end
            end
            ST_OWN: begin
                // Owner release wins over a coincident snoop request: no snoop outside a transaction.
                if (!owner_req) begin
                    state_next    = ST_TURN;
                    gnt_proc_next = '0;
                    owner_next    = '0;
                end else if (snp_any) begin
                    state_next     = ST_OWN_SNP;
                    gnt_snoop_next = snp_gnt;
                    snp_idx_next   = snp_idx;
                end
            end
            ST_OWN_SNP: begin
                if (!owner_req && !snooper_req) begin
                    state_next     = ST_TURN;
                    gnt_proc_next  = '0;
                    gnt_snoop_next = '0;
                    owner_next     = '0;
                end else if (!owner_req) begin
                    state_next    = ST_DRAIN;
                    gnt_proc_next = '0;
                    owner_next    = '0;
                end else if (!snooper_req) begin
                    state_next     = ST_OWN;
                    gnt_snoop_next = '0;
                end
            end
            ST_DRAIN: begin
                if (!snooper_req) begin
                    state_next     = ST_TURN;
                    gnt_snoop_next = '0;
                end
            end
            ST_TURN: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next     = ST_IDLE;
                gnt_proc_next  = '0;
                gnt_snoop_next = '0;
                owner_next     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            gnt_proc_reg  <= '0;
            gnt_snoop_reg <= '0;
            owner_reg     <= '0;
            snp_idx_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            gnt_proc_reg  <= gnt_proc_next;
            gnt_snoop_reg <= gnt_snoop_next;
            owner_reg     <= owner_next;
            snp_idx_reg   <= snp_idx_next;
        end
    end

    assign bus.Com_Bus_Gnt_proc  = gnt_proc_reg;
    assign bus.Com_Bus_Gnt_snoop = gnt_snoop_reg;
    assign bus.Bus_busy          = (state_reg != ST_IDLE);
    assign bus.Gnt_owner         = owner_reg;
endmodule
